// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: trigger modes, FSM states
// and the position of the mode field inside the trigger config word.
package acq_pkg;

  localparam logic [7:0] MODE_UNTRIG = 8'd0;
  localparam logic [7:0] MODE_GT     = 8'd1;
  localparam logic [7:0] MODE_LT     = 8'd2;
  localparam logic [7:0] MODE_IMM    = 8'd3;
  localparam logic [7:0] MODE_HARD   = 8'd4;

  localparam int MODE_MSB = 23;
  localparam int MODE_LSB = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    WAIT_TRIG,
    POSTTRIG,
    DONE
  } acq_state_e;

endpackage

// File: rtl/acq_len_counter.sv
// Loadable down-counter used for the pre- and post-trigger sample counts.
// last_o flags that the next decrement brings the count to zero.
module acq_len_counter #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         last_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (dec_i)
      count_d = count_q - W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign zero_o = (count_q == '0);
  assign last_o = (count_q == W'(1));

endmodule

// File: rtl/acq_sequencer.sv
// Sequences one acquisition around trigger_unit: arm, pre-trigger fill, wait for
// trigger, post-trigger capture, hand-off to readout via done/rd_ack.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [7:0]        cfg_mode,
  input  logic [15:0]       cfg_threshold,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] post_len,
  input  logic              adc_valid,
  input  logic              trig_condition,
  input  logic              rd_ack,
  output logic [WIDTH-1:0]  trig_cfg,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int SUM_W = ADDR_W + 2;
  localparam logic [SUM_W-1:0] DEPTH_W = {2'b01, {ADDR_W{1'b0}}};

  acq_state_e        state_q, state_d;
  logic [7:0]        mode_q, mode_d;
  logic [15:0]       thr_q, thr_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [WIDTH-1:0]  trig_cfg_q, trig_cfg_d;
  logic              cfg_err_q, cfg_err_d;

  logic              cnt_load, cnt_zero, cnt_last;
  logic [CNT_W-1:0]  cnt_val;
  logic              arm_fits;

  assign arm_fits = ({2'b00, pre_len} + {2'b00, post_len} + SUM_W'(1)) <= DEPTH_W;
  assign wr_en    = adc_valid && (state_q inside {PRETRIG, WAIT_TRIG, POSTTRIG});

  acq_len_counter #(.W(CNT_W)) u_len_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (wr_en && !cnt_zero),
    .zero_o     (cnt_zero),
    .last_o     (cnt_last)
  );

  // NOTE: every output of this block gets a default first, so no branch can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    thr_d       = thr_q;
    post_d      = post_q;
    wr_addr_d   = wr_en ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
    trig_addr_d = trig_addr_q;
    cfg_err_d   = 1'b0;
    cnt_load    = 1'b0;
    cnt_val     = '0;

    unique case (state_q)
      IDLE: begin
        if (arm) begin
          if (!arm_fits) begin
            cfg_err_d = 1'b1;
          end else begin
            mode_d    = cfg_mode;
            thr_d     = cfg_threshold;
            post_d    = post_len;
            wr_addr_d = '0;
            cnt_load  = 1'b1;
            cnt_val   = {1'b0, pre_len};
            state_d   = (pre_len == '0) ? WAIT_TRIG : PRETRIG;
          end
        end
      end
      PRETRIG:  if (wr_en && cnt_last) state_d = WAIT_TRIG;
      WAIT_TRIG: begin
        // With no sample this cycle the next write lands on wr_addr anyway,
        // so the trigger address is the current write pointer in both cases.
        if (trig_condition && mode_q != MODE_UNTRIG) begin
          trig_addr_d = wr_addr_q;
          if (adc_valid && post_q == '0) begin
            state_d = DONE;
          end else begin
            state_d  = POSTTRIG;
            cnt_load = 1'b1;
            cnt_val  = {1'b0, post_q} + {{ADDR_W{1'b0}}, ~adc_valid};
          end
        end
      end
      POSTTRIG: if (wr_en && cnt_last) state_d = DONE;
      DONE:     if (rd_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (abort) begin
      state_d     = IDLE;
      mode_d      = mode_q;
      thr_d       = thr_q;
      post_d      = post_q;
      wr_addr_d   = wr_addr_q;
      trig_addr_d = trig_addr_q;
      cfg_err_d   = 1'b0;
      cnt_load    = 1'b0;
    end

    trig_cfg_d = '0;
    trig_cfg_d[MODE_MSB:MODE_LSB] = (state_d == WAIT_TRIG) ? mode_d : MODE_UNTRIG;
    trig_cfg_d[15:0] = thr_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_UNTRIG;
      thr_q       <= '0;
      post_q      <= '0;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      trig_cfg_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      post_q      <= post_d;
      wr_addr_q   <= wr_addr_d;
      trig_addr_q <= trig_addr_d;
      trig_cfg_q  <= trig_cfg_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign trig_cfg  = trig_cfg_q;
  assign wr_addr   = wr_addr_q;
  assign trig_addr = trig_addr_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = state_q inside {PRETRIG, WAIT_TRIG, POSTTRIG};
  assign done      = (state_q == DONE);

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Controller that sequences one acquisition around trigger_unit: arm, pre-trigger fill, wait for trigger, post-trigger capture, then hand-off to readout.
- Drives trigger_unit's config word: the mode field is forced to untriggered except while waiting for a trigger.
- Generates write enable and address for a circular sample buffer of DEPTH = 2^ADDR_W entries.
- Reports the buffer address of the trigger sample to readout.

Parameters:
WIDTH, 24, width of trigger config word; [23:16] = mode, [15:0] = threshold
ADDR_W, 12, sample buffer address width; DEPTH = 2^ADDR_W

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
arm  in  1  start acquisition (sampled in IDLE only)
abort  in  1  cancel acquisition from any state
cfg_mode  in  8  trigger mode to apply while waiting (0 UNTRIG, 1 GT, 2 LT, 3 IMM, 4 HARD)
cfg_threshold  in  16  threshold forwarded to trigger_unit
pre_len  in  ADDR_W  samples to capture before trigger is enabled
post_len  in  ADDR_W  samples to capture after the trigger sample
adc_valid  in  1  new ADC sample present this cycle
trig_condition  in  1  from trigger_unit
rd_ack  in  1  readout finished; releases DONE
trig_cfg  out  WIDTH  config word to trigger_unit (registered)
wr_en  out  1  buffer write strobe
wr_addr  out  ADDR_W  buffer write address (registered)
trig_addr  out  ADDR_W  address of trigger sample
busy  out  1  acquisition in progress
done  out  1  capture complete, buffer valid
cfg_err  out  1  one-cycle pulse: arm rejected

Behaviour:
- Reset (async): state IDLE, trig_cfg={8'd0,16'h0}, wr_addr=0, trig_addr=0, busy=0, done=0, cfg_err=0.
- wr_en = adc_valid AND state in {PRETRIG, WAIT_TRIG, POSTTRIG}; combinational, no added latency. wr_addr increments by 1 after each write and wraps DEPTH-1 -> 0.
- IDLE:
  - arm=1 latches cfg_mode, cfg_threshold, pre_len and post_len, and sets wr_addr=0, busy=1.
  - Next state is PRETRIG, or WAIT_TRIG if pre_len=0.
  - If pre_len+post_len+1 > DEPTH (computed ADDR_W+2 bits wide), the arm is rejected: cfg_err pulses 1 cycle and the block stays in IDLE.
- PRETRIG:
  - trig_cfg mode=0.
  - Counts writes; after the pre_len-th write goes to WAIT_TRIG.
  - trig_condition is ignored.
- WAIT_TRIG:
  - trig_cfg={latched mode, latched threshold}, updated on the cycle of entry.
  - Writes continue circularly.
  - On the first cycle trig_condition=1:
    - if adc_valid=1 that cycle: trig_addr = current wr_addr, and that sample is the trigger sample;
    - if adc_valid=0: trig_addr = address of the next write, and the next valid sample is the trigger sample;
    - then go to POSTTRIG, with trig_cfg mode=0 from the next cycle.
  - Mode UNTRIG waits indefinitely; only abort exits.
  - HARD single-cycle pulses are accepted regardless of adc_valid.
- POSTTRIG:
  - Writes the trigger sample (if still pending), then post_len further samples.
  - After the last write goes to DONE. With post_len=0, DONE follows the trigger-sample write.
- DONE: done=1, busy=0, wr_en=0; arm is ignored; rd_ack=1 -> IDLE with done=0 next cycle.
- Abort in any state: IDLE next cycle, done=0, busy=0, trig_cfg mode=0; wr_addr and trig_addr hold. Abort dominates arm, trig_condition and rd_ack.
- Simultaneous trig_condition and pre-count completion in PRETRIG: the trigger is ignored, because triggers are armed only from WAIT_TRIG.
- Reset mid-operation: immediate return to reset values; no partial done.

Decomposition:
- acq_pkg holds:
  - the MODE_UNTRIG/GT/LT/IMM/HARD constants;
  - the state enum (IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE);
  - the trig_cfg field offsets (MODE_MSB=23, MODE_LSB=16).
- One sub-module, acq_len_counter: a loadable down-counter with zero flag, used for the pre and post counts.
- Address wrap stays in the top level.

Test Plan (ADDR_W=4, DEPTH=16, adc_valid=1 continuously unless stated):
- arm with pre_len=3, post_len=4, mode=3 (IMM) -> 3 writes with trig_cfg[23:16]=0; trig_cfg=0x03xxxx on entering WAIT_TRIG; trigger at wr_addr 3 (trig_condition from trigger_unit) -> trig_addr=3; 4 more writes; done=1 with wr_addr=8.
- mode=1 (GT), threshold 0x1000, pre_len=2, 20 samples before trigger -> wr_addr wraps 15->0; trig_addr=(2+20) mod 16=6; done after 6+post_len writes.
- pre_len=10, post_len=6 (10+6+1=17>16) -> cfg_err pulse, busy stays 0, state IDLE.
- mode=4 (HARD), trig_condition 1-cycle pulse while adc_valid=0 -> trig_addr = next write address; capture completes normally.
- abort asserted in POSTTRIG after 2 of 4 post writes -> IDLE next cycle, done never asserts, trig_cfg mode=0.
- DONE held 5 cycles with arm=1 -> no re-arm; rd_ack -> IDLE; reset asserted in WAIT_TRIG -> all outputs at reset values immediately.
